// File: rtl/vga_sync_receiver_if.sv
// rtl/vga_sync_receiver_if.sv - sync input and regenerated timing bundle for vga_sync_receiver
interface vga_sync_receiver_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        locked;
  logic        frame_start;
  logic        sync_err;
  logic [10:0] h_period;
  logic [9:0]  v_lines;

  modport master (
    output pix_en, hsync, vsync,
    input  pixel_x, pixel_y, video_on, locked, frame_start, sync_err, h_period, v_lines
  );

  modport slave (
    input  pix_en, hsync, vsync,
    output pixel_x, pixel_y, video_on, locked, frame_start, sync_err, h_period, v_lines
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver with flywheel counters, timing checks and lock FSM
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic                clk,
  input logic                rst,
  vga_sync_receiver_if.slave bus
);

  localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_TOTAL  = 11'(H_TOTAL_I);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL_I - 1);
  localparam logic [10:0] H_LOAD   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] H_TMO    = 11'(2 * H_TOTAL_I - 1);
  localparam logic [10:0] H_MAX    = 11'h7FF;

  localparam logic [9:0]  V_TOTAL  = 10'(V_TOTAL_I);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL_I - 1);
  localparam logic [9:0]  V_LOAD   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  LN_TMO   = 10'(V_TOTAL_I + 1);
  localparam logic [9:0]  LN_MAX   = 10'h3FF;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic        hs_prev, vs_prev;
  logic [10:0] h_cnt, h_per, h_low;
  logic [9:0]  v_cnt, ln;
  logic        h_ref, v_ref;
  logic        frame_err;
  logic [1:0]  state;

  logic        hfall, hrise, vfall;
  logic        h_wrap;
  logic [10:0] h_nxt, h_per_nxt, h_low_nxt, h_period_nxt;
  logic [9:0]  v_nxt, ln_nxt, v_lines_nxt;
  logic        err;
  logic [1:0]  state_nxt;
  logic        frame_err_nxt;

  always_comb begin
    hfall = bus.pix_en && hs_prev && !bus.hsync;
    hrise = bus.pix_en && !hs_prev && bus.hsync;
    vfall = bus.pix_en && vs_prev && !bus.vsync;

    // hfall load wins over the increment; vfall load is applied after the h wrap.
    h_wrap = 1'b0;
    h_nxt  = h_cnt;
    if (hfall) begin
      h_nxt = H_LOAD;
    end else if (bus.pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt  = 11'd0;
        h_wrap = 1'b1;
      end else begin
        h_nxt = h_cnt + 11'd1;
      end
    end

    v_nxt = v_cnt;
    if (vfall) begin
      v_nxt = V_LOAD;
    end else if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end

    h_per_nxt    = h_per;
    h_period_nxt = bus.h_period;
    if (hfall) begin
      h_per_nxt    = 11'd0;
      h_period_nxt = (h_per == H_MAX) ? H_MAX : h_per + 11'd1;
    end else if (bus.pix_en && h_per != H_MAX) begin
      h_per_nxt = h_per + 11'd1;
    end

    h_low_nxt = h_low;
    if (hfall) begin
      h_low_nxt = 11'd1;
    end else if (bus.pix_en && !bus.hsync && h_low != H_MAX) begin
      h_low_nxt = h_low + 11'd1;
    end

    ln_nxt      = ln;
    v_lines_nxt = bus.v_lines;
    if (vfall) begin
      ln_nxt      = 10'd0;
      v_lines_nxt = ln;
    end else if (hfall && ln != LN_MAX) begin
      ln_nxt = ln + 10'd1;
    end

    // The first edge after reset has no reference interval, so its check is skipped.
    err = (hfall && h_ref && (h_per + 11'd1 != H_TOTAL))
       || (hrise && h_ref && (h_low != H_SYNC_W))
       || (vfall && v_ref && (ln != V_TOTAL))
       || ((h_per_nxt == H_TMO) && (h_per != H_TMO))
       || ((ln_nxt == LN_TMO) && (ln != LN_TMO));

    state_nxt     = state;
    frame_err_nxt = frame_err | err;
    case (state)
      ST_HUNT: begin
        if (vfall) begin
          state_nxt     = ST_MEASURE;
          frame_err_nxt = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (vfall) begin
          if (!(frame_err || err)) begin
            state_nxt = ST_LOCKED;
          end
          frame_err_nxt = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (err) begin
          state_nxt = ST_HUNT;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_prev         <= 1'b1;
      vs_prev         <= 1'b1;
      h_cnt           <= 11'd0;
      v_cnt           <= 10'd0;
      h_per           <= 11'd0;
      h_low           <= 11'd0;
      ln              <= 10'd0;
      h_ref           <= 1'b0;
      v_ref           <= 1'b0;
      frame_err       <= 1'b0;
      state           <= ST_HUNT;
      bus.pixel_x     <= 10'd0;
      bus.pixel_y     <= 10'd0;
      bus.video_on    <= 1'b0;
      bus.locked      <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.sync_err    <= 1'b0;
      bus.h_period    <= 11'd0;
      bus.v_lines     <= 10'd0;
    end else begin
      if (bus.pix_en) begin
        hs_prev <= bus.hsync;
        vs_prev <= bus.vsync;
      end
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      h_per           <= h_per_nxt;
      h_low           <= h_low_nxt;
      ln              <= ln_nxt;
      h_ref           <= h_ref | hfall;
      v_ref           <= v_ref | vfall;
      frame_err       <= frame_err_nxt;
      state           <= state_nxt;
      bus.pixel_x     <= h_nxt[9:0];
      bus.pixel_y     <= v_nxt;
      bus.video_on    <= (state_nxt == ST_LOCKED) && (h_nxt < H_VIS) && (v_nxt < V_VIS);
      bus.locked      <= (state_nxt == ST_LOCKED);
      bus.frame_start <= bus.pix_en && (state_nxt == ST_LOCKED) && (h_nxt == 11'd0) && (v_nxt == 10'd0);
      bus.sync_err    <= err;
      bus.h_period    <= h_period_nxt;
      bus.v_lines     <= v_lines_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a reduced 32x15 raster
module tb_vga_sync_receiver;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = 32;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3, VT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_sync_receiver_if bus ();

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;
  int fs_pulses = 0;
  int e0 = 0;

  int gx = 0, gy = 0;
  int short_line = -1;
  int narrow_line = -1;
  bit hold_high = 1'b0;
  int pe_div = 4;

  always @(negedge clk) begin
    if (bus.sync_err === 1'b1) err_pulses++;
    if (bus.frame_start === 1'b1) fs_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic gen_hs();
    int lo_end;
    lo_end = (gy == narrow_line) ? HA + HF + HS - 1 : HA + HF + HS;
    return hold_high || !(gx >= HA + HF && gx < lo_end);
  endfunction

  function automatic logic gen_vs();
    return !(gy >= VA + VF && gy < VA + VF + VS);
  endfunction

  task automatic advance();
    int len;
    len = (gy == short_line) ? HT - 1 : HT;
    gx++;
    if (gx >= len) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    bus.pix_en = 1'b1;
    bus.hsync  = gen_hs();
    bus.vsync  = gen_vs();
    @(posedge clk);
    #1;
    bus.pix_en = 1'b0;
    advance();
  endtask

  task automatic step();
    idle(pe_div - 1);
    sample();
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  // Stops with (x, y) as the next position to be sampled; y < 0 matches any line.
  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(gx == x && (y < 0 || gy == y)) && n < 5000) begin
      step();
      n++;
    end
    check("reach", 32'(gx == x && (y < 0 || gy == y)), 32'd1);
  endtask

  initial begin
    bus.pix_en = 1'b0;
    bus.hsync  = 1'b1;
    bus.vsync  = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_x", 32'(bus.pixel_x), 32'd0);
    check("rst_pixel_y", 32'(bus.pixel_y), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_video_on", 32'(bus.video_on), 32'd0);
    check("rst_h_period", 32'(bus.h_period), 32'd0);
    check("rst_v_lines", 32'(bus.v_lines), 32'd0);
    check("rst_sync_err", 32'(bus.sync_err), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    rst = 1'b1;

    // Ideal stream, strobe every 4th clk
    pe_div = 4;
    run_to(0, 10);
    step();
    check("A_vfall1_locked", 32'(bus.locked), 32'd0);
    check("A_align_x", 32'(bus.pixel_x), 32'd0);
    check("A_align_y", 32'(bus.pixel_y), 32'd10);
    run_to(0, 10);
    check("A_pre_lock", 32'(bus.locked), 32'd0);
    step();
    check("A_lock", 32'(bus.locked), 32'd1);
    check("A_h_period", 32'(bus.h_period), 32'd32);
    check("A_v_lines", 32'(bus.v_lines), 32'd15);
    run_to(0, 0);
    step();
    check("A_fs", 32'(bus.frame_start), 32'd1);
    check("A_von_00", 32'(bus.video_on), 32'd1);
    check("A_origin_xy", 32'({bus.pixel_x, bus.pixel_y}), 32'd0);
    idle(1);
    check("A_fs_width", 32'(bus.frame_start), 32'd0);
    check("A_hold_x", 32'(bus.pixel_x), 32'd0);
    run_to(15, 0);
    step();
    check("A_von_x_last", 32'(bus.video_on), 32'd1);
    step();
    check("A_von_x_edge", 32'(bus.video_on), 32'd0);
    check("A_x_edge", 32'(bus.pixel_x), 32'd16);
    run_to(0, 7);
    step();
    check("A_von_y_last", 32'(bus.video_on), 32'd1);
    run_to(0, 8);
    step();
    check("A_von_y_edge", 32'(bus.video_on), 32'd0);
    run_to(0, 10);
    step();
    check("A_still_locked", 32'(bus.locked), 32'd1);
    check("A_no_err", 32'(err_pulses), 32'd0);
    check("A_fs_count", 32'(fs_pulses), 32'd1);

    // One short line
    pe_div = 2;
    short_line = 12;
    run_to(20, 13);
    check("B_pre", 32'(bus.locked), 32'd1);
    step();
    short_line = -1;
    check("B_h_period", 32'(bus.h_period), 32'd31);
    check("B_sync_err", 32'(bus.sync_err), 32'd1);
    check("B_unlock", 32'(bus.locked), 32'd0);
    idle(1);
    check("B_err_width", 32'(bus.sync_err), 32'd0);
    run_to(0, 10);
    step();
    check("B_relock1", 32'(bus.locked), 32'd0);
    run_to(0, 10);
    step();
    check("B_relock2", 32'(bus.locked), 32'd1);
    check("B_err_count", 32'(err_pulses), 32'd1);

    // Narrow hsync pulse
    narrow_line = 2;
    run_to(25, 2);
    check("C_pre_err", 32'(bus.sync_err), 32'd0);
    step();
    narrow_line = -1;
    check("C_sync_err", 32'(bus.sync_err), 32'd1);
    check("C_unlock", 32'(bus.locked), 32'd0);
    run_to(0, 10);
    step();
    run_to(0, 10);
    step();
    check("C_relock", 32'(bus.locked), 32'd1);
    check("C_err_count", 32'(err_pulses), 32'd2);

    // hsync stuck high: timeout, then saturation
    run_to(0, 3);
    hold_high = 1'b1;
    run_to(19, 4);
    check("D_pre", 32'(bus.locked), 32'd1);
    check("D_pre_err", 32'(bus.sync_err), 32'd0);
    step();
    check("D_tmo_err", 32'(bus.sync_err), 32'd1);
    check("D_unlock", 32'(bus.locked), 32'd0);
    run_n(2100);
    run_to(0, 11);
    hold_high = 1'b0;
    run_to(20, -1);
    step();
    check("D_sat", 32'(bus.h_period), 32'd2047);
    check("D_sat_err", 32'(bus.sync_err), 32'd1);
    run_to(0, 10);
    step();
    check("D_relock1", 32'(bus.locked), 32'd0);
    run_to(0, 10);
    step();
    check("D_relock2", 32'(bus.locked), 32'd1);

    // Mid-line reset while locked
    run_to(5, 3);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("E_pixel_x", 32'(bus.pixel_x), 32'd0);
    check("E_pixel_y", 32'(bus.pixel_y), 32'd0);
    check("E_locked", 32'(bus.locked), 32'd0);
    check("E_h_period", 32'(bus.h_period), 32'd0);
    check("E_v_lines", 32'(bus.v_lines), 32'd0);
    check("E_video_on", 32'(bus.video_on), 32'd0);
    e0 = err_pulses;
    run_to(0, 10);
    step();
    check("E_relock1", 32'(bus.locked), 32'd0);
    run_to(0, 10);
    step();
    check("E_relock2", 32'(bus.locked), 32'd1);
    check("E_h_period2", 32'(bus.h_period), 32'd32);
    check("E_v_lines2", 32'(bus.v_lines), 32'd15);
    check("E_no_err", 32'(err_pulses), 32'(e0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
